// File: rtl/regs_wr_arbiter.sv
// Two-requester round-robin arbiter driving a registered register-file write port.
// Optional macro REGS_ARB_PROTECT_EN: writes to addresses 0 and 1 are accepted, dropped and counted.
module regs_wr_arbiter #(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned REG_ADDR_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      hold,

    input  logic                      a_valid,
    input  logic [REG_ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0]     a_data,
    output logic                      a_ready,

    input  logic                      b_valid,
    input  logic [REG_ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0]     b_data,
    output logic                      b_ready,

    output logic                      en_write,
    output logic [REG_ADDR_WIDTH-1:0] addr_write,
    output logic [DATA_WIDTH-1:0]     data_write,
    output logic [7:0]                drop_cnt
);

    typedef enum logic {
        GrantA = 1'b0,
        GrantB = 1'b1
    } grant_e;

    grant_e                    r_last_grant;
    grant_e                    w_last_grant_d;
    logic                      w_a_grant;
    logic                      w_b_grant;
    logic                      w_xfer;
    logic                      w_drop;
    logic                      w_fwd;
    logic [REG_ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0]     w_sel_data;

    logic                      r_en_write;
    logic [REG_ADDR_WIDTH-1:0] r_addr_write;
    logic [DATA_WIDTH-1:0]     r_data_write;

    // Readys are gated by rst_n so nothing can be accepted while reset is asserted.
    always_comb begin
        w_a_grant = 1'b0;
        w_b_grant = 1'b0;
        if (rst_n && !hold) begin
            if (a_valid && (!b_valid || (r_last_grant == GrantB))) begin
                w_a_grant = 1'b1;
            end else if (b_valid) begin
                w_b_grant = 1'b1;
            end
        end
    end

    assign a_ready = w_a_grant;
    assign b_ready = w_b_grant;
    assign w_xfer  = w_a_grant | w_b_grant;

    always_comb begin
        w_sel_addr = b_addr;
        w_sel_data = b_data;
        if (w_a_grant) begin
            w_sel_addr = a_addr;
            w_sel_data = a_data;
        end
    end

    // Grant history only moves on an actual transfer; hold leaves it untouched.
    always_comb begin
        w_last_grant_d = r_last_grant;
        if (w_a_grant) begin
            w_last_grant_d = GrantA;
        end else if (w_b_grant) begin
            w_last_grant_d = GrantB;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= GrantB;
        end else begin
            r_last_grant <= w_last_grant_d;
        end
    end

`ifdef REGS_ARB_PROTECT_EN
    logic [7:0] r_drop_cnt;

    // Addresses 0 and 1 are the protected registers.
    assign w_drop = w_xfer && ((w_sel_addr >> 1) == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= 8'd0;
        end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign drop_cnt = r_drop_cnt;
`else
    assign w_drop   = 1'b0;
    assign drop_cnt = 8'd0;
`endif

    assign w_fwd = w_xfer && !w_drop;

    // Address/data only load on a forwarded write so they hold between writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en_write   <= 1'b0;
            r_addr_write <= '0;
            r_data_write <= '0;
        end else begin
            r_en_write <= w_fwd;
            if (w_fwd) begin
                r_addr_write <= w_sel_addr;
                r_data_write <= w_sel_data;
            end
        end
    end

    assign en_write   = r_en_write;
    assign addr_write = r_addr_write;
    assign data_write = r_data_write;

    a_one_ready: assert property (@(posedge clk) disable iff (!rst_n) !(a_ready && b_ready));

endmodule

// File: tb/tb_regs_wr_arbiter.sv
// Scoreboard bench for regs_wr_arbiter: stimulus pushes expected writes, a monitor pops them.
// Build with REGS_ARB_PROTECT_EN defined to exercise the protected-address path.
module tb_regs_wr_arbiter;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 4;

    logic          clk;
    logic          rst_n;
    logic          hold;
    logic          a_valid;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_data;
    logic          a_ready;
    logic          b_valid;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_data;
    logic          b_ready;
    logic          en_write;
    logic [AW-1:0] addr_write;
    logic [DW-1:0] data_write;
    logic [7:0]    drop_cnt;

    int n_vec;
    int n_err;
    logic [AW+DW-1:0] exp_q[$];

    regs_wr_arbiter #(
        .DATA_WIDTH     (DW),
        .REG_ADDR_WIDTH (AW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hold       (hold),
        .a_valid    (a_valid),
        .a_addr     (a_addr),
        .a_data     (a_data),
        .a_ready    (a_ready),
        .b_valid    (b_valid),
        .b_addr     (b_addr),
        .b_data     (b_data),
        .b_ready    (b_ready),
        .en_write   (en_write),
        .addr_write (addr_write),
        .data_write (data_write),
        .drop_cnt   (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Every issued write is compared in grant order against the expected queue.
    always @(negedge clk) begin
        if (rst_n && en_write) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(en_write), 32'd0);
            end else begin
                check("write_addr_data", 32'({addr_write, data_write}), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_vec   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        hold    = 1'b0;
        a_valid = 1'b1;
        b_valid = 1'b1;
        a_addr  = 4'd3;
        a_data  = 16'h1111;
        b_addr  = 4'd6;
        b_data  = 16'h2222;

        // Reset state, with both valids high to show readys are gated.
        repeat (2) @(posedge clk);
        #2;
        check("rst_en_write", 32'(en_write), 32'd0);
        check("rst_addr_write", 32'(addr_write), 32'd0);
        check("rst_data_write", 32'(data_write), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        check("rst_a_ready", 32'(a_ready), 32'd0);
        check("rst_b_ready", 32'(b_ready), 32'd0);
        a_valid = 1'b0;
        b_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Single A request.
        step();
        a_valid = 1'b1;
        a_addr  = 4'd5;
        a_data  = 16'h1234;
        #1;
        check("single_a_ready", 32'(a_ready), 32'd1);
        check("single_b_ready", 32'(b_ready), 32'd0);
        exp_q.push_back({4'd5, 16'h1234});
        step();
        a_valid = 1'b0;
        check("single_en_1", 32'(en_write), 32'd1);
        step();
        check("single_en_0", 32'(en_write), 32'd0);
        check("single_addr_hold", 32'(addr_write), 32'd5);

        // Contention right after reset, both to the same address: A, B, A, B.
        rst_n = 1'b0;
        #2;
        rst_n   = 1'b1;
        a_valid = 1'b1;
        b_valid = 1'b1;
        a_addr  = 4'd7;
        b_addr  = 4'd7;
        a_data  = 16'hAAAA;
        b_data  = 16'hBBBB;
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("cont_a_ready_%0d", i), 32'(a_ready), 32'(i % 2 == 0));
            check($sformatf("cont_b_ready_%0d", i), 32'(b_ready), 32'(i % 2 == 1));
            exp_q.push_back((i % 2 == 0) ? {4'd7, 16'hAAAA} : {4'd7, 16'hBBBB});
            step();
            check($sformatf("cont_en_%0d", i), 32'(en_write), 32'd1);
        end

        // Hold blocks both; release grants A since B went last.
        hold = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("hold_a_ready_%0d", i), 32'(a_ready), 32'd0);
            check($sformatf("hold_b_ready_%0d", i), 32'(b_ready), 32'd0);
            step();
            check($sformatf("hold_en_%0d", i), 32'(en_write), 32'd0);
        end
        hold = 1'b0;
        #1;
        check("release_a_ready", 32'(a_ready), 32'd1);
        check("release_b_ready", 32'(b_ready), 32'd0);
        exp_q.push_back({4'd7, 16'hAAAA});
        step();
        a_valid = 1'b0;
        #1;
        check("release_b_next", 32'(b_ready), 32'd1);
        exp_q.push_back({4'd7, 16'hBBBB});
        step();
        b_valid = 1'b0;

        // Single B request after B just won: still granted when alone.
        b_valid = 1'b1;
        b_addr  = 4'd9;
        b_data  = 16'h0F0F;
        #1;
        check("single_b_ready_b", 32'(b_ready), 32'd1);
        check("single_b_ready_a", 32'(a_ready), 32'd0);
        exp_q.push_back({4'd9, 16'h0F0F});
        step();
        b_valid = 1'b0;
        step();

        // Reset lands while an accepted A write is being presented.
        a_valid = 1'b1;
        a_addr  = 4'd4;
        a_data  = 16'h4444;
        #1;
        check("mid_a_ready", 32'(a_ready), 32'd1);
        step();
        rst_n   = 1'b0;
        b_valid = 1'b1;
        #1;
        check("mid_rst_en", 32'(en_write), 32'd0);
        check("mid_rst_addr", 32'(addr_write), 32'd0);
        check("mid_rst_data", 32'(data_write), 32'd0);
        check("mid_rst_a_ready", 32'(a_ready), 32'd0);
        check("mid_rst_b_ready", 32'(b_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_a_ready", 32'(a_ready), 32'd1);
        check("post_rst_b_ready", 32'(b_ready), 32'd0);
        exp_q.push_back({4'd4, 16'h4444});
        step();
        a_valid = 1'b0;
        #1;
        check("post_rst_b_next", 32'(b_ready), 32'd1);
        exp_q.push_back({4'd9, 16'h0F0F});
        step();
        b_valid = 1'b0;
        step();

`ifdef REGS_ARB_PROTECT_EN
        // Protected address: accepted, dropped, counted with saturation.
        b_valid = 1'b1;
        b_addr  = 4'd1;
        b_data  = 16'h00FF;
        #1;
        check("prot_b_ready", 32'(b_ready), 32'd1);
        step();
        check("prot_en", 32'(en_write), 32'd0);
        check("prot_drop_1", 32'(drop_cnt), 32'd1);
        repeat (299) step();
        check("prot_drop_sat", 32'(drop_cnt), 32'd255);
        check("prot_en_sat", 32'(en_write), 32'd0);
        b_addr = 4'd0;
        step();
        check("prot_addr0_en", 32'(en_write), 32'd0);
        check("prot_addr0_drop", 32'(drop_cnt), 32'd255);
        b_addr = 4'd2;
        b_data = 16'h0202;
        exp_q.push_back({4'd2, 16'h0202});
        step();
        b_valid = 1'b0;
        check("prot_addr2_en", 32'(en_write), 32'd1);
`else
        // Without protection, address 1 is forwarded and nothing is counted.
        b_valid = 1'b1;
        b_addr  = 4'd1;
        b_data  = 16'h00FF;
        #1;
        check("noprot_b_ready", 32'(b_ready), 32'd1);
        exp_q.push_back({4'd1, 16'h00FF});
        step();
        b_valid = 1'b0;
        check("noprot_en", 32'(en_write), 32'd1);
        check("noprot_drop", 32'(drop_cnt), 32'd0);
`endif

        repeat (3) step();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
